// File: rtl/arb_pkg.sv
// Shared constants, state encoding and pointer helper for the round-robin encoder arbiter.
package arb_pkg;

    localparam int unsigned ARB_N        = 4;
    localparam int unsigned ARB_IDXW     = $clog2(ARB_N);
    localparam int unsigned ARB_MAX_HOLD = 16;

    typedef logic [0:0] arb_state_t;

    localparam arb_state_t IDLE  = 1'b0;
    localparam arb_state_t GRANT = 1'b1;

    // Priority pointer advance with wrap-around at n.
    function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/onehot_encoder.sv
// Combinational one-hot to binary index encoder; all-zero input encodes to 0.
module onehot_encoder #(
    parameter int unsigned N    = 4,
    parameter int unsigned IDXW = $clog2(N)
) (
    input  logic [N-1:0]    onehot_i,
    output logic [IDXW-1:0] idx_o
);

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot_i[i]) begin
                idx_o = idx_o | IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter with held grants and a registered binary grant index.
// Define ARB_TIMEOUT_EN to force a release after MAX_HOLD grant cycles.
module rr_encoder_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned N        = ARB_N,
    parameter int unsigned IDXW     = $clog2(N),
    parameter int unsigned MAX_HOLD = ARB_MAX_HOLD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [N-1:0]    grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            grant_valid,
    output logic            timeout
);

    if (N < 2 || MAX_HOLD < 2) begin : g_bad_param
        $error("rr_encoder_arbiter: N and MAX_HOLD must both be at least 2");
    end

    arb_state_t      state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IDXW-1:0] grant_idx_q, grant_idx_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [N-1:0]    sel_onehot;
    logic            rel_normal;
    logic            rel_forced;

    // First set request at or cyclically after the priority pointer.
    always_comb begin
        logic found;
        int unsigned cand;
        sel_onehot = '0;
        found      = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr_q) + k) % N;
            if (!found && req[cand]) begin
                sel_onehot[cand] = 1'b1;
                found            = 1'b1;
            end
        end
    end

    onehot_encoder #(
        .N    (N),
        .IDXW (IDXW)
    ) u_encoder (
        .onehot_i (grant_d),
        .idx_o    (grant_idx_d)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;

    // The grant has been visible for hold_q+1 cycles in the current GRANT cycle.
    assign rel_forced = (state_q == GRANT) && !rel_normal && (hold_q == HOLD_W'(MAX_HOLD - 1));

    always_comb begin
        hold_d    = hold_q;
        timeout_d = 1'b0;
        if (state_q == IDLE) begin
            hold_d = '0;
        end else begin
            hold_d    = hold_q + 1'b1;
            timeout_d = rel_forced;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign rel_forced = 1'b0;
    assign timeout    = 1'b0;
`endif

    assign rel_normal = (state_q == GRANT) && (done || !req[grant_idx_q]);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = sel_onehot;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (rel_normal || rel_forced) begin
                    grant_d = '0;
                    state_d = IDLE;
                    ptr_d   = IDXW'(next_ptr(int'(grant_idx_q), N));
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            ptr_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = |grant_q;

endmodule
